// File: rtl/sa_pkg.sv
// Shared types and default widths for the output-stationary systolic array.
package sa_pkg;

  localparam int SA_D_W   = 8;
  localparam int SA_ACC_W = 24;
  localparam int SA_M_MAX = 128;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DONE
  } sa_state_e;

endpackage

// File: rtl/sa_array_core_if.sv
// Feeder-side bundle of the systolic array: control, operand vectors, status and result grid.
interface sa_array_core_if #(
   parameter int D_W   = sa_pkg::SA_D_W,
   parameter int X_R   = 16,
   parameter int W_C   = 16,
   parameter int ACC_W = sa_pkg::SA_ACC_W
);
   logic                                  I_START;
   logic                                  I_EN;
   logic [7:0]                            I_M_DIM;
   logic [X_R-1:0][D_W-1:0]               I_X_VECTOR;
   logic [W_C-1:0][D_W-1:0]               I_W_VECTOR;
   logic                                  O_PE_SHIFT;
   logic                                  O_BUSY;
   logic                                  O_DONE;
   logic [X_R-1:0][W_C-1:0][ACC_W-1:0]    O_RESULT;

   modport master (
      output I_START, I_EN, I_M_DIM, I_X_VECTOR, I_W_VECTOR,
      input  O_PE_SHIFT, O_BUSY, O_DONE, O_RESULT
   );

   modport slave (
      input  I_START, I_EN, I_M_DIM, I_X_VECTOR, I_W_VECTOR,
      output O_PE_SHIFT, O_BUSY, O_DONE, O_RESULT
   );
endinterface

// File: rtl/sa_pe.sv
// One processing element: forwards x right and w down, accumulates the signed product.
module sa_pe #(
   parameter int D_W   = sa_pkg::SA_D_W,
   parameter int ACC_W = sa_pkg::SA_ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             step,
   input  logic [D_W-1:0]   x_in,
   input  logic [D_W-1:0]   w_in,
   output logic [D_W-1:0]   x_out,
   output logic [D_W-1:0]   w_out,
   output logic [ACC_W-1:0] acc
);
   logic signed [2*D_W-1:0] prod;
   logic signed [ACC_W-1:0] prod_ext;

   assign prod     = $signed(x_in) * $signed(w_in);
   assign prod_ext = ACC_W'(prod);

   // NOTE: sequential state uses non-blocking assignments so every PE samples its neighbour's old value.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         x_out <= '0;
         w_out <= '0;
         acc   <= '0;
      end else if (step) begin
         x_out <= x_in;
         w_out <= w_in;
         acc   <= acc + prod_ext;
      end
   end
endmodule

// File: rtl/sa_array_core.sv
// Output-stationary X_R x W_C systolic array with input skew lines and FEED/FLUSH run control.
module sa_array_core
   import sa_pkg::*;
#(
   parameter int D_W   = SA_D_W,
   parameter int X_R   = 16,
   parameter int W_C   = 16,
   parameter int ACC_W = SA_ACC_W
) (
   input logic           I_CLK,
   input logic           I_RST,
   sa_array_core_if.slave bus
);
   localparam int FLUSH_N = X_R + W_C - 2;

   sa_state_e  state;
   logic [7:0] cnt;
   logic [7:0] m_q;
   logic       busy;
   logic       done;
   logic       step;
   logic       start_go;

   logic [X_R-1:0][D_W-1:0]            x_feed, x_edge;
   logic [W_C-1:0][D_W-1:0]            w_feed, w_edge;
   logic [D_W-1:0]                     x_pipe [X_R][W_C];
   logic [D_W-1:0]                     w_pipe [X_R][W_C];
   logic [X_R-1:0][W_C-1:0][ACC_W-1:0] acc_grid;

   assign step     = ((state == FEED) || (state == FLUSH)) && bus.I_EN;
   assign start_go = bus.I_START && bus.I_EN;

   // FLUSH pushes zeros so late-arriving lanes finish without picking up feeder junk.
   assign x_feed = (state == FEED) ? bus.I_X_VECTOR : '0;
   assign w_feed = (state == FEED) ? bus.I_W_VECTOR : '0;

   assign bus.O_PE_SHIFT = step;
   assign bus.O_BUSY     = busy;
   assign bus.O_DONE     = done;
   assign bus.O_RESULT   = acc_grid;

   for (genvar gi = 0; gi < X_R; gi++) begin : g_xskew
      if (gi == 0) begin : g_direct
         assign x_edge[gi] = x_feed[gi];
      end else begin : g_delay
         logic [D_W-1:0] sk [gi];
         // NOTE: skew storage is explicitly cleared on reset and start; stale lanes would corrupt the next run.
         always_ff @(posedge I_CLK) begin
            if (I_RST || start_go) begin
               for (int k = 0; k < gi; k++) sk[k] <= '0;
            end else if (step) begin
               sk[0] <= x_feed[gi];
               for (int k = 1; k < gi; k++) sk[k] <= sk[k-1];
            end
         end
         assign x_edge[gi] = sk[gi-1];
      end
   end

   for (genvar gj = 0; gj < W_C; gj++) begin : g_wskew
      if (gj == 0) begin : g_direct
         assign w_edge[gj] = w_feed[gj];
      end else begin : g_delay
         logic [D_W-1:0] sk [gj];
         always_ff @(posedge I_CLK) begin
            if (I_RST || start_go) begin
               for (int k = 0; k < gj; k++) sk[k] <= '0;
            end else if (step) begin
               sk[0] <= w_feed[gj];
               for (int k = 1; k < gj; k++) sk[k] <= sk[k-1];
            end
         end
         assign w_edge[gj] = sk[gj-1];
      end
   end

   for (genvar gi = 0; gi < X_R; gi++) begin : g_row
      for (genvar gj = 0; gj < W_C; gj++) begin : g_col
         logic [D_W-1:0] x_in, w_in;
         if (gj == 0) begin : g_xl
            assign x_in = x_edge[gi];
         end else begin : g_xp
            assign x_in = x_pipe[gi][gj-1];
         end
         if (gi == 0) begin : g_wt
            assign w_in = w_edge[gj];
         end else begin : g_wp
            assign w_in = w_pipe[gi-1][gj];
         end
         sa_pe #(.D_W(D_W), .ACC_W(ACC_W)) u_pe (
            .clk   (I_CLK),
            .rst   (I_RST),
            .clr   (start_go),
            .step  (step),
            .x_in  (x_in),
            .w_in  (w_in),
            .x_out (x_pipe[gi][gj]),
            .w_out (w_pipe[gi][gj]),
            .acc   (acc_grid[gi][gj])
         );
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         state <= IDLE;
         cnt   <= '0;
         m_q   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else if (start_go) begin
         m_q <= bus.I_M_DIM;
         cnt <= '0;
         if (bus.I_M_DIM == 8'd0) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else begin
            state <= FEED;
            busy  <= 1'b1;
            done  <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: ;
            FEED: if (step) begin
               if (cnt == 8'(m_q - 8'd1)) begin
                  cnt <= '0;
                  if (FLUSH_N == 0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= FLUSH;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            FLUSH: if (step) begin
               if (cnt == 8'(FLUSH_N - 1)) begin
                  cnt   <= '0;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            // The done pulse retires even while stalled so it is always one cycle wide.
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
